// File: rtl/soc_bus_pkg.sv
// Shared definitions for the single-master bus controller: address map
// defaults, error data, FSM encoding, slave select indices and the region decoder.
package soc_bus_pkg;

    localparam logic [11:0] ROM_REGION_DEF     = 12'h001;
    localparam logic [11:0] RAM_REGION_DEF     = 12'h000;
    localparam logic [11:0] PER_REGION_DEF     = 12'h020;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
    localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

    localparam int SEL_ROM    = 0;
    localparam int SEL_RAM    = 1;
    localparam int SEL_PER    = 2;
    localparam int NUM_SLAVES = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

    // One-hot slave select from the top address nibbles; all-zero means unmapped.
    function automatic logic [NUM_SLAVES-1:0] decode_region(
        input logic [11:0] region,
        input logic [11:0] rom_region,
        input logic [11:0] ram_region,
        input logic [11:0] per_region
    );
        logic [NUM_SLAVES-1:0] sel;
        sel          = '0;
        sel[SEL_ROM] = (region == rom_region);
        sel[SEL_RAM] = (region == ram_region);
        sel[SEL_PER] = (region == per_region);
        return sel;
    endfunction

endpackage

// File: rtl/soc_bus_ctrl_timeout.sv
// Watchdog counter for the bus controller: cleared when a slave access
// starts, counts while the access is outstanding, flags the last allowed cycle.
module bus_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/soc_bus_ctrl.sv
// Single-master bus controller: PicoRV32 native interface to ROM, RAM and a
// peripheral window, one transaction at a time, with watchdog and error capture.
module soc_bus_ctrl
    import soc_bus_pkg::*;
#(
    parameter logic [11:0] ROM_REGION     = ROM_REGION_DEF,
    parameter logic [11:0] RAM_REGION     = RAM_REGION_DEF,
    parameter logic [11:0] PER_REGION     = PER_REGION_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        rom_valid,
    output logic        ram_valid,
    output logic        per_valid,
    input  logic        rom_ready,
    input  logic        ram_ready,
    input  logic        per_ready,
    input  logic [31:0] rom_rdata,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] per_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        err_flag,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    bus_state_e            state_q,     state_d;
    logic [NUM_SLAVES-1:0] sel_q,       sel_d;
    logic [NUM_SLAVES-1:0] valid_q,     valid_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic [31:0]           s_addr_q,    s_addr_d;
    logic [31:0]           s_wdata_q,   s_wdata_d;
    logic [3:0]            s_wstrb_q,   s_wstrb_d;
    logic                  err_flag_q,  err_flag_d;
    logic [31:0]           err_addr_q,  err_addr_d;

    logic [NUM_SLAVES-1:0] req_sel;
    logic                  req_bad;
    logic                  err_set;
    logic [31:0]           err_set_addr;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_expired;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    bus_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // Decode the incoming request: unmapped, or a write aimed at the ROM, is refused.
    always_comb begin
        req_sel = decode_region(mem_addr[31:20], ROM_REGION, RAM_REGION, PER_REGION);
        req_bad = (req_sel == '0) || (req_sel[SEL_ROM] && (mem_wstrb != 4'd0));
    end

    // Route the ready and read data of the slave owning the current access.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'd0;
        if (sel_q[SEL_ROM]) begin
            sel_ready = rom_ready;
            sel_rdata = rom_rdata;
        end else if (sel_q[SEL_RAM]) begin
            sel_ready = ram_ready;
            sel_rdata = ram_rdata;
        end else if (sel_q[SEL_PER]) begin
            sel_ready = per_ready;
            sel_rdata = per_rdata;
        end
    end

    // Transaction FSM next-state and registered-output logic; readys are only honoured in ACCESS.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        valid_d      = valid_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        err_set      = 1'b0;
        err_set_addr = s_addr_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    s_addr_d  = mem_addr;
                    s_wdata_d = mem_wdata;
                    s_wstrb_d = mem_wstrb;
                    sel_d     = req_sel;
                    if (req_bad) begin
                        state_d      = ST_DONE;
                        valid_d      = '0;
                        mem_ready_d  = 1'b1;
                        mem_rdata_d  = ERR_DATA;
                        err_set      = 1'b1;
                        err_set_addr = mem_addr;
                    end else begin
                        state_d = ST_ACCESS;
                        valid_d = req_sel;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (sel_ready) begin
                    state_d     = ST_DONE;
                    valid_d     = '0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = (s_wstrb_q != 4'd0) ? 32'd0 : sel_rdata;
                end else if (cnt_expired) begin
                    state_d     = ST_DONE;
                    valid_d     = '0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ERR_DATA;
                    err_set     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = '0;
            end
        endcase
    end

    // Sticky error capture: a new error beats a coincident clear and re-loads the address.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_set) begin
            err_flag_d = 1'b1;
            if (!err_flag_q || err_clr) begin
                err_addr_d = err_set_addr;
            end
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any access in flight without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            valid_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            s_wstrb_q   <= 4'd0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign rom_valid = valid_q[SEL_ROM];
    assign ram_valid = valid_q[SEL_RAM];
    assign per_valid = valid_q[SEL_PER];
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign err_flag  = err_flag_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Directed testbench for soc_bus_ctrl: slave responses are driven step by
// step and every observation is compared against hand-computed values.
module tb_soc_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        rom_valid, ram_valid, per_valid;
    logic        rom_ready, ram_ready, per_ready;
    logic [31:0] rom_rdata, ram_rdata, per_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    soc_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .rom_valid (rom_valid),
        .ram_valid (ram_valid),
        .per_valid (per_valid),
        .rom_ready (rom_ready),
        .ram_ready (ram_ready),
        .per_ready (per_ready),
        .rom_rdata (rom_rdata),
        .ram_rdata (ram_rdata),
        .per_rdata (per_rdata),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_valid = valid;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Count cycles until mem_ready (the request cycle counts as cycle 1) and
    // tally how many sampled cycles each slave valid was high.
    task automatic waitResponse(input int maxCycles, output int lat, output logic seen,
                                output int romCnt, output int ramCnt, output int perCnt);
        lat    = 1;
        seen   = 1'b0;
        romCnt = 0;
        ramCnt = 0;
        perCnt = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            lat++;
            if (mem_ready) begin
                seen = 1'b1;
            end else begin
                if (rom_valid) romCnt++;
                if (ram_valid) ramCnt++;
                if (per_valid) perCnt++;
            end
        end
    endtask

    int   lat;
    logic seen;
    int   romCnt, ramCnt, perCnt;

    initial begin
        rst       = 1'b1;
        err_clr   = 1'b0;
        rom_ready = 1'b0;
        ram_ready = 1'b0;
        per_ready = 1'b0;
        rom_rdata = 32'd0;
        ram_rdata = 32'd0;
        per_rdata = 32'd0;
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        checkOutput("rst_valids", {29'd0, rom_valid, ram_valid, per_valid}, 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);
        checkOutput("rst_err", {31'd0, err_flag} | err_addr, 32'd0);
        rst = 1'b0;
        tick();

        // 1: ROM read, ready one edge after valid rises
        applyStimulus(1'b1, 32'h0010_0008, 32'd0, 4'd0);
        tick();
        checkOutput("t1_rom_valid", {31'd0, rom_valid}, 32'd1);
        checkOutput("t1_other_valid", {30'd0, ram_valid, per_valid}, 32'd0);
        checkOutput("t1_no_ready_yet", {31'd0, mem_ready}, 32'd0);
        checkOutput("t1_s_addr", s_addr, 32'h0010_0008);
        rom_ready = 1'b1;
        rom_rdata = 32'h0000_0213;
        tick();
        checkOutput("t1_mem_ready_cycle3", {31'd0, mem_ready}, 32'd1);
        checkOutput("t1_rdata", mem_rdata, 32'h0000_0213);
        checkOutput("t1_rom_valid_drop", {31'd0, rom_valid}, 32'd0);
        checkOutput("t1_err_flag", {31'd0, err_flag}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        rom_ready = 1'b0;
        tick();
        checkOutput("t1_ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        checkOutput("t1_rdata_hold", mem_rdata, 32'h0000_0213);

        // 2: ROM ready held two cycles, then back-to-back read
        applyStimulus(1'b1, 32'h0010_0004, 32'd0, 4'd0);
        tick();
        rom_ready = 1'b1;
        rom_rdata = 32'h0000_0113;
        tick();
        checkOutput("t2_first_ready", {31'd0, mem_ready}, 32'd1);
        checkOutput("t2_first_rdata", mem_rdata, 32'h0000_0113);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        checkOutput("t2_no_spurious", {31'd0, mem_ready}, 32'd0);
        rom_ready = 1'b0;
        rom_rdata = 32'h0000_0293;
        applyStimulus(1'b1, 32'h0010_000C, 32'd0, 4'd0);
        tick();
        checkOutput("t2_second_access", {31'd0, rom_valid, mem_ready}, 32'd2);
        tick();
        checkOutput("t2_waits_fresh_ready", {31'd0, mem_ready}, 32'd0);
        rom_ready = 1'b1;
        tick();
        checkOutput("t2_second_ready", {31'd0, mem_ready}, 32'd1);
        checkOutput("t2_second_rdata", mem_rdata, 32'h0000_0293);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        rom_ready = 1'b0;
        tick();

        // 3: unmapped read, then clear the error
        applyStimulus(1'b1, 32'h0300_0000, 32'd0, 4'd0);
        waitResponse(8, lat, seen, romCnt, ramCnt, perCnt);
        checkOutput("t3_resp_seen", {31'd0, seen}, 32'd1);
        checkOutput("t3_latency", lat, 32'd2);
        checkOutput("t3_rdata", mem_rdata, 32'hDEAD_BEEF);
        checkOutput("t3_err_flag", {31'd0, err_flag}, 32'd1);
        checkOutput("t3_err_addr", err_addr, 32'h0300_0000);
        checkOutput("t3_no_valid", romCnt + ramCnt + perCnt, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t3_err_cleared", {31'd0, err_flag}, 32'd0);

        // 4: peripheral never ready -> watchdog; later RAM write timeout keeps err_addr
        applyStimulus(1'b1, 32'h0200_0004, 32'd0, 4'd0);
        waitResponse(40, lat, seen, romCnt, ramCnt, perCnt);
        checkOutput("t4_resp_seen", {31'd0, seen}, 32'd1);
        checkOutput("t4_per_valid_cycles", perCnt, 32'd16);
        checkOutput("t4_rdata", mem_rdata, 32'hDEAD_BEEF);
        checkOutput("t4_err_flag", {31'd0, err_flag}, 32'd1);
        checkOutput("t4_err_addr", err_addr, 32'h0200_0004);
        checkOutput("t4_per_valid_drop", {31'd0, per_valid}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b1, 32'h0000_0040, 32'h0000_00AA, 4'h1);
        waitResponse(40, lat, seen, romCnt, ramCnt, perCnt);
        checkOutput("t4b_resp_seen", {31'd0, seen}, 32'd1);
        checkOutput("t4b_ram_valid_cycles", ramCnt, 32'd16);
        checkOutput("t4b_rdata", mem_rdata, 32'hDEAD_BEEF);
        checkOutput("t4b_err_addr_kept", err_addr, 32'h0200_0004);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // 5: ROM write refused (with a coincident clear), then a good RAM write
        applyStimulus(1'b1, 32'h0010_0000, 32'h5555_AAAA, 4'hF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t5_rom_wr_ready", {31'd0, mem_ready}, 32'd1);
        checkOutput("t5_rom_wr_rdata", mem_rdata, 32'hDEAD_BEEF);
        checkOutput("t5_rom_valid", {31'd0, rom_valid}, 32'd0);
        checkOutput("t5_err_flag", {31'd0, err_flag}, 32'd1);
        checkOutput("t5_err_addr_new", err_addr, 32'h0010_0000);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
        ram_rdata = 32'hFFFF_FFFF;
        tick();
        checkOutput("t5_ram_valid", {31'd0, ram_valid}, 32'd1);
        checkOutput("t5_s_addr", s_addr, 32'h0000_0010);
        checkOutput("t5_s_wdata", s_wdata, 32'h1234_5678);
        checkOutput("t5_s_wstrb", {28'd0, s_wstrb}, 32'hF);
        tick();
        checkOutput("t5_ram_valid_held", {31'd0, ram_valid, mem_ready}, 32'd2);
        ram_ready = 1'b1;
        tick();
        checkOutput("t5_wr_ready", {31'd0, mem_ready}, 32'd1);
        checkOutput("t5_wr_rdata_zero", mem_rdata, 32'd0);
        checkOutput("t5_ram_valid_drop", {31'd0, ram_valid}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        ram_ready = 1'b0;
        tick();

        // 6: reset in the middle of an access, then a normal read
        applyStimulus(1'b1, 32'h0000_0020, 32'd0, 4'd0);
        tick();
        checkOutput("t6_ram_access", {31'd0, ram_valid}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("t6_rst_valids", {29'd0, rom_valid, ram_valid, per_valid}, 32'd0);
        checkOutput("t6_rst_s_addr", s_addr, 32'd0);
        checkOutput("t6_rst_rdata", mem_rdata, 32'd0);
        checkOutput("t6_rst_err", {31'd0, err_flag} | err_addr, 32'd0);
        rst = 1'b0;
        ram_rdata = 32'hCAFE_0001;
        tick();
        checkOutput("t6_restart_access", {31'd0, ram_valid, mem_ready}, 32'd2);
        ram_ready = 1'b1;
        tick();
        checkOutput("t6_ready", {31'd0, mem_ready}, 32'd1);
        checkOutput("t6_rdata", mem_rdata, 32'hCAFE_0001);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
        ram_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_bus_ctrl.md
Name: soc_bus_ctrl

Overview:
- Single-master bus controller between the PicoRV32 native memory interface and three slaves: program ROM, data RAM, peripheral window.
- Decodes the address, forwards one transaction at a time and registers the response.
- Provides a timeout watchdog and an error response for unmapped or illegal accesses.
- Shields the CPU from slaves whose registered ready can stay high for an extra cycle.

Parameters:
- ROM_REGION, 12'h001, addr[31:20] value selecting program ROM
- RAM_REGION, 12'h000, addr[31:20] value selecting data RAM
- PER_REGION, 12'h020, addr[31:20] value selecting peripherals
- TIMEOUT_CYCLES, 16, cycles in ACCESS without slave ready before an error response (range 2..255)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error response

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  CPU request valid, held until mem_ready
- mem_ready  out  1  one-cycle response strobe to CPU
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; 0 = read
- mem_rdata  out  32  registered response data
- rom_valid/ram_valid/per_valid  out  1 each  slave request
- rom_ready/ram_ready/per_ready  in  1 each  slave ready
- rom_rdata/ram_rdata/per_rdata  in  32 each  slave read data
- s_addr  out  32  registered address to all slaves
- s_wdata  out  32  registered write data
- s_wstrb  out  4  registered byte strobes
- err_flag  out  1  sticky error indicator
- err_addr  out  32  address of the first error since the last clear
- err_clr  in  1  clears err_flag; err_addr is then re-armed

Behaviour:
- Reset: state=IDLE, all outputs 0, counter 0. rst mid-transaction aborts it; no mem_ready is issued.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE
  - On mem_valid, register addr/wdata/wstrb onto s_*.
  - Decode addr[31:20] into a one-hot select.
  - Mapped and legal: go to ACCESS.
  - Unmapped, or write (wstrb != 0) to ROM: go to DONE with error.
  - Slave readys are ignored in IDLE.
- ACCESS
  - The selected *_valid is high; the others stay 0.
  - Counter increments from 0 each cycle.
  - On the selected slave ready: capture its rdata into mem_rdata and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ready: go to DONE with error.
  - Ready takes priority over timeout in the same cycle.
- DONE
  - mem_ready=1 for exactly one cycle; all *_valid=0; stale slave ready ignored.
  - Next state is IDLE.
- Latency: a slave whose ready arrives k cycles after its valid rises gives mem_ready at cycle k+2 after mem_valid is first seen. For the ROM (k=1), mem_ready comes 3 cycles after mem_valid.
- Error response: mem_rdata=ERR_DATA and err_flag set.
  - err_addr is loaded only if err_flag was 0.
  - If err_clr coincides with a new error, the new error wins: flag stays 1 and err_addr is loaded with the new address.
- mem_rdata holds its value until the next DONE. On writes, mem_rdata is 0 (writes to RAM/PER).
- mem_valid dropping during ACCESS (illegal per protocol): the transaction still completes.
- Back-to-back: the CPU may raise a new mem_valid in the cycle after DONE; it is accepted from IDLE, giving a one-cycle bubble minimum.

Decomposition:
- Package soc_bus_pkg holds:
  - region constants
  - ERR_DATA
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - slave select index constants
- One natural sub-module: bus_timeout_cnt, an 8-bit counter with clear/enable/expired output.

Test Plan:
1. ROM read at 0x0010_0008, ROM model returns ready 1 cycle after valid with 0x00000213 -> mem_ready exactly 3 cycles after mem_valid, mem_rdata=0x00000213, rom_valid high exactly 1 cycle, err_flag=0.
2. ROM model holding ready high for 2 cycles, followed by a back-to-back read of 0x0010_000C -> one mem_ready per transaction, second rdata=0x00000293, no spurious response.
3. Read 0x0300_0000 (unmapped) -> mem_ready 2 cycles after valid, rdata=0xDEADBEEF, err_flag=1, err_addr=0x0300_0000, no slave valid. Then pulse err_clr -> err_flag=0.
4. PER read where the slave never readies -> per_valid high 16 cycles, then mem_ready with 0xDEADBEEF and err_flag=1. A later RAM write error does not overwrite err_addr.
5. Write wstrb=4'hF to 0x0010_0000 -> error response, rom_valid never asserted. RAM write 0x0000_0010 data 0x1234_5678 -> s_wdata/s_wstrb match, ram_valid until ready.
6. Assert rst during ACCESS -> next cycle all outputs 0, no mem_ready. A following read completes normally.
